rx_segment_router: RTL and testbench

//  Parametrised front end for the redundant-frame receive path. Reads the segment ID from each

---
 rtl/rx_segment_router_pkg.sv | 13 +
 rtl/rx_segment_router_if.sv | 24 ++
 rtl/rx_segment_router_delay_line.sv | 21 ++
 rtl/rx_segment_router.sv | 172 +++++++++++++++++
 tb/tb_rx_segment_router.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/rx_segment_router_pkg.sv
// rx_seg_pkg: shared types and helpers for rx_segment_router (FSM states, decision record, latency)
package rx_seg_pkg;
  localparam int MAX_CH = 256;
  localparam int CH_W = $clog2(MAX_CH);
  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;
  typedef struct packed {
    logic            keep;
    logic [CH_W-1:0] ch;
  } dec_t;
  function automatic int lat(input int off, input int bytes);
    return off + bytes + 1;
  endfunction
endpackage

// File: rtl/rx_segment_router_if.sv
// rx_seg_if: GMII receive side plus per-segment lane outputs; RX_SEG_STATS_EN adds counters
interface rx_seg_if #(parameter int NUM_CH = 50);
  logic [7:0]        rx_data;
  logic              rx_enable;
  logic [NUM_CH-1:0] ch_en;
  logic [7:0]        ch_data;
  logic              ch_sof;
  logic              ch_eof;
  logic              drop_pulse;
  logic              dec_ovf;
`ifdef RX_SEG_STATS_EN
  logic [NUM_CH*16-1:0] frame_cnt;
  logic [15:0]          drop_cnt;
  modport master (output rx_data, rx_enable,
                  input ch_en, ch_data, ch_sof, ch_eof, drop_pulse, dec_ovf, frame_cnt, drop_cnt);
  modport slave  (input rx_data, rx_enable,
                  output ch_en, ch_data, ch_sof, ch_eof, drop_pulse, dec_ovf, frame_cnt, drop_cnt);
`else
  modport master (output rx_data, rx_enable,
                  input ch_en, ch_data, ch_sof, ch_eof, drop_pulse, dec_ovf);
  modport slave  (input rx_data, rx_enable,
                  output ch_en, ch_data, ch_sof, ch_eof, drop_pulse, dec_ovf);
`endif
endinterface

// File: rtl/rx_segment_router_delay_line.sv
// rx_seg_delay_line: fixed-depth shift register with async active-low reset
module rx_seg_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             rx_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_sr [DEPTH];
  // shift one stage per cycle, independent of the input stream
  always_ff @(posedge rx_clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/rx_segment_router.sv
// rx_segment_router: routes GMII frames to per-segment lanes by header ID; RX_SEG_STATS_EN adds frame/drop counters
module rx_segment_router
  import rx_seg_pkg::*;
#(
  parameter int NUM_CH        = 50,
  parameter int SEG_ID_OFFSET = 21,
  parameter int SEG_ID_BYTES  = 2,
  parameter int ID_BASE       = 0,
  parameter int DEC_DEPTH     = 2
) (
  input logic     rx_clk,
  input logic     reset,
  rx_seg_if.slave bus
);
  localparam int LAT   = lat(SEG_ID_OFFSET, SEG_ID_BYTES);
  localparam int IW    = 8 * SEG_ID_BYTES;
  localparam int ID_HI = SEG_ID_OFFSET + SEG_ID_BYTES - 1;
  localparam int QW    = DEC_DEPTH > 1 ? $clog2(DEC_DEPTH) : 1;
  typedef logic [QW:0] qc_t;

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  logic [7:0]    r_in_data;
  logic          r_in_vld;
  logic [15:0]   r_cnt;
  state_t        r_state;
  logic [IW-1:0] r_id;
  logic [IW-1:0] w_id_nxt;
  logic [32:0]   w_rel;
  logic          w_hdr, w_id_byte, w_id_last, w_push;
  dec_t          w_push_dec;
  logic [7:0]    r_d1_data;
  logic          r_d1_vld, r_d1_sof;
  logic [10:0]   w_line_in, w_line_out;
  logic          w_lo_vld, w_lo_sof, w_lo_eof;
  logic [7:0]    w_lo_data;
  dec_t          r_q [DEC_DEPTH];
  logic [QW-1:0] r_wp, r_rp, w_wp_nxt, w_rp_nxt;
  qc_t           r_q_cnt, r_hole_n;
  logic          r_hole;
  logic          w_q_empty, w_q_full, w_hole_hit, w_pop, w_deq, w_acc, w_lost;
  dec_t          w_pop_dec, r_dec, w_dec;
  logic          w_fire;

  // async assert, synchronous release of the internal reset
  always_ff @(posedge rx_clk or negedge reset)
    if (!reset) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];

  // register the GMII inputs and count bytes of the current valid run
  always_ff @(posedge rx_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_in_data <= '0;
      r_in_vld  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_in_data <= bus.rx_data;
      r_in_vld  <= bus.rx_enable;
      r_cnt     <= !r_in_vld ? '0 : (&r_cnt) ? r_cnt : r_cnt + 16'd1;
    end

  assign w_hdr      = r_state != BODY;
  assign w_id_byte  = r_in_vld && w_hdr && r_cnt >= 16'(SEG_ID_OFFSET) && r_cnt <= 16'(ID_HI);
  assign w_id_last  = r_in_vld && w_hdr && r_cnt == 16'(ID_HI);
  assign w_id_nxt   = IW'({r_id, r_in_data});
  assign w_rel      = 33'(w_id_nxt) - 33'(ID_BASE);
  assign w_push     = w_id_last || (r_state == HDR && !r_in_vld);
  assign w_push_dec = '{keep: w_id_last && !w_rel[32] && w_rel < 33'(NUM_CH), ch: w_rel[CH_W-1:0]};

  // header capture: assemble the big-endian ID, then wait out the body
  always_ff @(posedge rx_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_id    <= '0;
    end else begin
      if (w_id_byte) r_id <= w_id_nxt;
      r_state <= !r_in_vld ? IDLE : (r_state == BODY || w_id_last) ? BODY : HDR;
    end

  // first delay stage: marks sof, and eof once the run is seen to have ended
  always_ff @(posedge rx_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_d1_data <= '0;
      r_d1_vld  <= 1'b0;
      r_d1_sof  <= 1'b0;
    end else begin
      r_d1_data <= r_in_data;
      r_d1_vld  <= r_in_vld;
      r_d1_sof  <= r_in_vld && !r_d1_vld;
    end

  assign w_line_in = {r_d1_vld, r_d1_sof, r_d1_vld && !r_in_vld, r_d1_data};

  rx_seg_delay_line #(.DEPTH(LAT - 1), .WIDTH(11)) u_dly (
    .rx_clk(rx_clk),
    .reset (w_rst_n),
    .i_d   (w_line_in),
    .o_q   (w_line_out)
  );

  assign {w_lo_vld, w_lo_sof, w_lo_eof, w_lo_data} = w_line_out;

  assign w_q_empty  = r_q_cnt == '0;
  assign w_q_full   = r_q_cnt == qc_t'(DEC_DEPTH);
  assign w_hole_hit = r_hole && r_hole_n == '0;
  assign w_pop      = w_lo_vld && w_lo_sof;
  assign w_deq      = w_pop && !w_q_empty && !w_hole_hit;
  assign w_acc      = w_push && (!w_q_full || w_deq);
  assign w_lost     = w_push && !w_acc;
  assign w_wp_nxt   = r_wp == QW'(DEC_DEPTH - 1) ? '0 : r_wp + 1'b1;
  assign w_rp_nxt   = r_rp == QW'(DEC_DEPTH - 1) ? '0 : r_rp + 1'b1;
  assign w_pop_dec  = w_deq ? r_q[r_rp] : '0;
  assign w_dec      = w_lo_sof ? w_pop_dec : r_dec;
  assign w_fire     = w_lo_vld && w_dec.keep;

  // decision queue; a discarded push leaves a marker so its frame is dropped in order
  always_ff @(posedge rx_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      for (int i = 0; i < DEC_DEPTH; i++) r_q[i] <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_q_cnt  <= '0;
      r_hole   <= 1'b0;
      r_hole_n <= '0;
    end else begin
      if (w_acc) begin
        r_q[r_wp] <= w_push_dec;
        r_wp      <= w_wp_nxt;
      end
      if (w_deq) r_rp <= w_rp_nxt;
      r_q_cnt <= r_q_cnt + qc_t'(w_acc) - qc_t'(w_deq);
      if (w_hole_hit || !r_hole) begin
        r_hole   <= w_lost;
        r_hole_n <= r_q_cnt;
      end else if (w_deq) r_hole_n <= r_hole_n - 1'b1;
    end

  // output stage: route each delayed byte by the decision latched at its sof
  always_ff @(posedge rx_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_dec          <= '0;
      bus.ch_en      <= '0;
      bus.ch_data    <= '0;
      bus.ch_sof     <= 1'b0;
      bus.ch_eof     <= 1'b0;
      bus.drop_pulse <= 1'b0;
      bus.dec_ovf    <= 1'b0;
    end else begin
      if (w_pop) r_dec <= w_pop_dec;
      bus.ch_en      <= w_fire ? NUM_CH'(1) << w_dec.ch : '0;
      if (w_fire) bus.ch_data <= w_lo_data;
      bus.ch_sof     <= w_fire && w_lo_sof;
      bus.ch_eof     <= w_fire && w_lo_eof;
      bus.drop_pulse <= w_pop && !w_pop_dec.keep;
      bus.dec_ovf    <= bus.dec_ovf || w_lost || (w_pop && w_q_empty && !w_hole_hit);
    end

`ifdef RX_SEG_STATS_EN
  // per-channel forwarded-frame counters and saturating drop counter
  always_ff @(posedge rx_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      bus.frame_cnt <= '0;
      bus.drop_cnt  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (w_fire && w_lo_eof && w_dec.ch == CH_W'(c))
          bus.frame_cnt[c*16 +: 16] <= bus.frame_cnt[c*16 +: 16] + 16'd1;
      if (w_pop && !w_pop_dec.keep && !(&bus.drop_cnt)) bus.drop_cnt <= bus.drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_rx_segment_router.sv
// tb_rx_segment_router: scoreboard bench for rx_segment_router (checks counters when RX_SEG_STATS_EN is defined)
module tb_rx_segment_router;
  import rx_seg_pkg::*;
  localparam int NUM_CH = 50;
  localparam int LAT = lat(21, 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  longint cyc = 0;
  int checks = 0;
  int errors = 0;
  int fno = 0;

  typedef struct {
    bit         drop;
    int         ch;
    logic [7:0] data;
    bit         sof;
    bit         eof;
    longint     at;
  } ev_t;
  ev_t exp_q[$];

  rx_seg_if #(.NUM_CH(NUM_CH)) bus ();
  rx_segment_router #(.NUM_CH(NUM_CH)) dut (.rx_clk(clk), .reset(rst_n), .bus(bus));

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // monitor: every output byte or drop pulse must match the head of the scoreboard
  always @(negedge clk) begin : mon
    ev_t e;
    bit ok;
    if (rst_n && (bus.ch_en != '0 || bus.drop_pulse)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out cyc=%0d ch_en=%h data=%h drop=%b", cyc, bus.ch_en, bus.ch_data, bus.drop_pulse);
      end else begin
        e = exp_q.pop_front();
        ok = e.drop ? (bus.drop_pulse && bus.ch_en == '0 && cyc == e.at)
                    : (!bus.drop_pulse && bus.ch_en == (NUM_CH'(1) << e.ch) && bus.ch_data == e.data &&
                       bus.ch_sof == e.sof && bus.ch_eof == e.eof && cyc == e.at);
        if (!ok) begin
          errors++;
          $display("FAIL lane_out cyc=%0d got ch_en=%h data=%h sof=%b eof=%b drop=%b want drop=%b ch=%0d data=%h sof=%b eof=%b at=%0d",
                   cyc, bus.ch_en, bus.ch_data, bus.ch_sof, bus.ch_eof, bus.drop_pulse,
                   e.drop, e.ch, e.data, e.sof, e.eof, e.at);
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ch_en"}, 64'(bus.ch_en), 64'd0);
    check({tag, "_ch_data"}, 64'(bus.ch_data), 64'd0);
    check({tag, "_ch_sof"}, 64'(bus.ch_sof), 64'd0);
    check({tag, "_ch_eof"}, 64'(bus.ch_eof), 64'd0);
    check({tag, "_drop"}, 64'(bus.drop_pulse), 64'd0);
    check({tag, "_dec_ovf"}, 64'(bus.dec_ovf), 64'd0);
  endtask

  // drive one frame; exp_ch < 0 means the frame must be dropped; rst_at >= 0 resets before that byte
  task automatic send_frame(input int len, input int id, input int exp_ch, input int gap, input int rst_at = -1);
    ev_t e;
    fno++;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      if (i == rst_at) begin
        rst_n = 1'b0;
        bus.rx_enable = 1'b0;
        exp_q.delete();
        #1;
        check_outputs_zero("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      bus.rx_enable = 1'b1;
      bus.rx_data = i == 21 ? 8'(id >> 8) : i == 22 ? 8'(id) : 8'(i * 3 + fno * 17);
      e = '{exp_ch < 0, exp_ch, bus.rx_data, i == 0, i == len - 1, cyc + LAT + 2};
      if (exp_ch >= 0 || i == 0) exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.rx_enable = 1'b0;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (LAT + 4) @(posedge clk);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_enable = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    send_frame(64, 7, 7, 12);
    drain("t1_id7");
    send_frame(64, 50, -1, 12);
    drain("t2_id50");
    check("t2_no_ovf", 64'(bus.dec_ovf), 64'd0);
    send_frame(20, 3, -1, 12);
    send_frame(64, 3, 3, 12);
    drain("t3_short_then_id3");
    send_frame(64, 1, 1, 12);
    send_frame(64, 2, 2, 12);
    drain("t4_back_to_back");
    send_frame(64, 49, 49, 4);
    send_frame(23, 0, 0, 4);
    send_frame(22, 0, -1, 4);
    send_frame(64, 16'h0107, -1, 4);
    drain("boundaries");
    check("boundaries_no_ovf", 64'(bus.dec_ovf), 64'd0);
    for (int k = 0; k < 5; k++) send_frame(1, 0, -1, 1);
    send_frame(64, 9, 9, 2);
    drain("overflow");
    check("ovf_sticky", 64'(bus.dec_ovf), 64'd1);
    send_frame(64, 6, 6, 12, 40);
    repeat (4) @(posedge clk);
    send_frame(64, 5, 5, 12);
    drain("t5_after_reset");
    check("ovf_cleared", 64'(bus.dec_ovf), 64'd0);
    for (int k = 0; k < 3; k++) send_frame(64, 4, 4, 4);
    send_frame(64, 60, -1, 4);
    send_frame(64, 16'hFFFF, -1, 4);
    drain("t6_stats");
`ifdef RX_SEG_STATS_EN
    check("frame_cnt4", 64'(bus.frame_cnt[4*16 +: 16]), 64'd3);
    check("frame_cnt5", 64'(bus.frame_cnt[5*16 +: 16]), 64'd1);
    check("drop_cnt", 64'(bus.drop_cnt), 64'd2);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
